// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types and sizes for the ALU issue unit
package alu_pkg;

    localparam int NREGS  = 8;
    localparam int REG_AW = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_NOT  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_unit_if.sv
// rtl/alu_issue_unit_if.sv - instruction issue handshake between upstream and the issue unit
interface alu_issue_unit_if #(
    parameter int N = 32
);
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [REG_AW-1:0] in_rd;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic              in_imm_en;
    logic [N-1:0]      in_imm;

    // Upstream instruction source
    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        input  in_ready
    );

    // Issue unit side
    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        output in_ready
    );

endinterface

// File: rtl/alu_issue_unit_regfile.sv
// rtl/alu_issue_unit_regfile.sv - 8-entry register file, two operand reads, one debug read, one write
module alu_issue_unit_regfile
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] raddr1,
    output logic [N-1:0]      rdata1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [N-1:0]      rdata2,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [N-1:0]      dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [N-1:0]      wdata
);

    logic [N-1:0] mem [NREGS];

    // Clear all entries on reset; r0 is never written so it stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // r0 reads as zero regardless of array contents
    always_comb begin
        rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
        rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
        dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
    end

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - issue/execute/writeback sequencer in front of an external combinational ALU
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_unit_if.slave   in_if,
    output logic [N-1:0]      alu_op1,
    output logic [N-1:0]      alu_op2,
    output logic [2:0]        alu_sel,
    input  logic [N-1:0]      alu_q,
    output logic              done,
    output logic [N-1:0]      result,
    output logic              zero,
    output logic              err,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [N-1:0]      dbg_data
);

    state_e            state_q;
    state_e            state_d;
    op_e               op_q;
    logic [REG_AW-1:0] rd_q;
    logic [N-1:0]      op1_q;
    logic [N-1:0]      op2_q;
    logic [N-1:0]      result_q;
    logic              zero_q;
    logic              err_q;

    logic [N-1:0]      rf_rdata1;
    logic [N-1:0]      rf_rdata2;
    logic              rf_we;
    logic              accept;

    assign accept = (state_q == IDLE) && in_if.in_valid;

    alu_issue_unit_regfile #(
        .N (N)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr1   (in_if.in_rs1),
        .rdata1   (rf_rdata1),
        .raddr2   (in_if.in_rs2),
        .rdata2   (rf_rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (result_q)
    );

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs: fixed three-cycle IDLE -> EXEC -> WB walk
    always_comb begin
        state_d         = state_q;
        in_if.in_ready  = 1'b0;
        done            = 1'b0;
        rf_we           = 1'b0;
        case (state_q)
            IDLE: begin
                in_if.in_ready = 1'b1;
                if (in_if.in_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                done    = 1'b1;
                rf_we   = !err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch at accept; register-form op2 comes from rs2, else from the immediate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_ADD;
            rd_q  <= '0;
            op1_q <= '0;
            op2_q <= '0;
        end else if (accept) begin
            op_q  <= op_e'(in_if.in_op);
            rd_q  <= in_if.in_rd;
            op1_q <= rf_rdata1;
            op2_q <= in_if.in_imm_en ? in_if.in_imm : rf_rdata2;
        end
    end

    // Result capture during EXEC; the reserved opcode retires zero with the error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (state_q == EXEC) begin
            if (op_q == OP_RSVD) begin
                result_q <= '0;
                zero_q   <= 1'b1;
                err_q    <= 1'b1;
            end else begin
                result_q <= alu_q;
                zero_q   <= (alu_q == '0);
                err_q    <= 1'b0;
            end
        end
    end

    assign alu_op1 = op1_q;
    assign alu_op2 = op2_q;
    assign alu_sel = op_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign err     = err_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - directed table-driven bench for alu_issue_unit with a behavioural ALU
module tb_alu_issue_unit;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic [N-1:0] alu_op1;
    logic [N-1:0] alu_op2;
    logic [2:0]   alu_sel;
    logic [N-1:0] alu_q;
    logic         done;
    logic [N-1:0] result;
    logic         zero;
    logic         err;
    logic [2:0]   dbg_addr;
    logic [N-1:0] dbg_data;

    int tests_run;
    int tests_failed;
    int cyc;
    int done_cnt;
    int acc_cyc[$];

    alu_issue_unit_if #(.N(N)) in_if ();

    alu_issue_unit #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_if    (in_if),
        .alu_op1  (alu_op1),
        .alu_op2  (alu_op2),
        .alu_sel  (alu_sel),
        .alu_q    (alu_q),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .err      (err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Behavioural model of the downstream combinational ALU
    always_comb begin
        alu_q = '0;
        case (alu_sel)
            3'd0: alu_q = alu_op1 + alu_op2;
            3'd1: alu_q = alu_op1 - alu_op2;
            3'd2: alu_q = alu_op1 * alu_op2;
            3'd3: alu_q = alu_op1 >> alu_op2;
            3'd4: alu_q = alu_op1 & alu_op2;
            3'd5: alu_q = alu_op1 | alu_op2;
            3'd6: alu_q = ~alu_op2;
            default: alu_q = 32'hDEAD_BEEF;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, accept log and done-pulse counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_if.in_valid && in_if.in_ready) acc_cyc.push_back(cyc);
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        imm_en;
        logic [31:0] imm;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_err;
        logic [2:0]  chk_reg;
        logic [31:0] exp_reg;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic valid);
        in_if.in_op     = v.op;
        in_if.in_rd     = v.rd;
        in_if.in_rs1    = v.rs1;
        in_if.in_rs2    = v.rs2;
        in_if.in_imm_en = v.imm_en;
        in_if.in_imm    = v.imm;
        in_if.in_valid  = valid;
    endtask

    task automatic run_instr(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'd0, in_if.in_ready}, 32'd1);
        drive(v, 1'b1);
        @(negedge clk);
        in_if.in_valid = 1'b0;
        check({tag, "_exec_done"}, {31'd0, done}, 32'd0);
        check({tag, "_exec_sel"}, {29'd0, alu_sel}, {29'd0, v.op});
        check({tag, "_exec_ready"}, {31'd0, in_if.in_ready}, 32'd0);
        @(negedge clk);
        check({tag, "_wb_done"}, {31'd0, done}, 32'd1);
        check({tag, "_wb_result"}, result, v.exp_res);
        check({tag, "_wb_zero"}, {31'd0, zero}, {31'd0, v.exp_zero});
        check({tag, "_wb_err"}, {31'd0, err}, {31'd0, v.exp_err});
        @(negedge clk);
        check({tag, "_post_done"}, {31'd0, done}, 32'd0);
        check({tag, "_post_ready"}, {31'd0, in_if.in_ready}, 32'd1);
        dbg_addr = v.chk_reg;
        #1;
        check({tag, "_reg"}, dbg_data, v.exp_reg);
    endtask

    initial begin
        vec_t a;
        vec_t b;
        int   n0;
        int   waited;
        int   dc;

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        done_cnt     = 0;
        rst          = 1'b0;
        dbg_addr     = '0;
        in_if.in_valid  = 1'b0;
        in_if.in_op     = '0;
        in_if.in_rd     = '0;
        in_if.in_rs1    = '0;
        in_if.in_rs2    = '0;
        in_if.in_imm_en = 1'b0;
        in_if.in_imm    = '0;

        //           op    rd    rs1   rs2   imm   imm           result        z     e     chk   reg
        vecs[0] = '{3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5,        32'd5,        1'b0, 1'b0, 3'd1, 32'd5};
        vecs[1] = '{3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 32'd7,        32'd7,        1'b0, 1'b0, 3'd2, 32'd7};
        vecs[2] = '{3'd1, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0,        32'hFFFF_FFFE, 1'b0, 1'b0, 3'd3, 32'hFFFF_FFFE};
        vecs[3] = '{3'd4, 3'd0, 3'd1, 3'd0, 1'b1, 32'd0,        32'd0,        1'b1, 1'b0, 3'd0, 32'd0};
        vecs[4] = '{3'd7, 3'd2, 3'd1, 3'd0, 1'b1, 32'd3,        32'd0,        1'b1, 1'b1, 3'd2, 32'd7};
        vecs[5] = '{3'd2, 3'd6, 3'd2, 3'd1, 1'b0, 32'd0,        32'd35,       1'b0, 1'b0, 3'd6, 32'd35};
        vecs[6] = '{3'd3, 3'd7, 3'd3, 3'd0, 1'b1, 32'd28,       32'h0000_000F, 1'b0, 1'b0, 3'd7, 32'h0000_000F};
        vecs[7] = '{3'd5, 3'd4, 3'd1, 3'd2, 1'b0, 32'd0,        32'd7,        1'b0, 1'b0, 3'd4, 32'd7};
        vecs[8] = '{3'd6, 3'd5, 3'd0, 3'd1, 1'b0, 32'd0,        32'hFFFF_FFFA, 1'b0, 1'b0, 3'd5, 32'hFFFF_FFFA};

        // Asynchronous reset and reset-value checks
        #2 rst = 1'b1;
        #1;
        check("rst_ready",  {31'd0, in_if.in_ready}, 32'd1);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero",   {31'd0, zero}, 32'd0);
        check("rst_err",    {31'd0, err}, 32'd0);
        check("rst_op1",    alu_op1, 32'd0);
        check("rst_op2",    alu_op2, 32'd0);
        check("rst_sel",    {29'd0, alu_sel}, 32'd0);
        check("rst_dbg",    dbg_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_instr(vecs[i], i);
        end

        // Back-to-back dependent pair with in_valid held high: R4=R1+3, R5=R4|8
        a = '{3'd0, 3'd4, 3'd1, 3'd0, 1'b1, 32'd3, 32'd8, 1'b0, 1'b0, 3'd4, 32'd8};
        b = '{3'd5, 3'd5, 3'd4, 3'd0, 1'b1, 32'd8, 32'd8, 1'b0, 1'b0, 3'd5, 32'd8};
        @(negedge clk);
        n0 = acc_cyc.size();
        drive(a, 1'b1);
        waited = 0;
        while (acc_cyc.size() < n0 + 1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("b2b_first_accept", {31'd0, acc_cyc.size() >= n0 + 1}, 32'd1);
        drive(b, 1'b1);
        waited = 0;
        while (acc_cyc.size() < n0 + 2 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        in_if.in_valid = 1'b0;
        check("b2b_second_accept", {31'd0, acc_cyc.size() >= n0 + 2}, 32'd1);
        if (acc_cyc.size() >= n0 + 2) begin
            check("b2b_spacing", acc_cyc[n0 + 1] - acc_cyc[n0], 32'd3);
        end
        @(negedge clk);
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_result", result, 32'd8);
        @(negedge clk);
        dbg_addr = 3'd4;
        #1 check("b2b_r4", dbg_data, 32'd8);
        dbg_addr = 3'd5;
        #1 check("b2b_r5", dbg_data, 32'd8);

        // Reset asserted during EXEC discards the instruction
        a = '{3'd0, 3'd6, 3'd0, 3'd0, 1'b1, 32'd9, 32'd9, 1'b0, 1'b0, 3'd6, 32'd0};
        @(negedge clk);
        drive(a, 1'b1);
        @(negedge clk);
        in_if.in_valid = 1'b0;
        check("mid_exec_state", {31'd0, in_if.in_ready}, 32'd0);
        dc = done_cnt;
        rst = 1'b1;
        #1;
        check("mid_rst_ready",  {31'd0, in_if.in_ready}, 32'd1);
        check("mid_rst_done",   {31'd0, done}, 32'd0);
        check("mid_rst_op2",    alu_op2, 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", done_cnt, dc);
        check("mid_rst_ready_after", {31'd0, in_if.in_ready}, 32'd1);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = r[2:0];
            #1 check($sformatf("mid_rst_r%0d", r), dbg_data, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential issue/writeback stage sitting directly upstream of the combinational ALU. Accepts one register-form or immediate-form instruction over a valid/ready handshake, fetches operands from an internal 8-entry register file, drives the ALU operand/select inputs, captures the ALU result and writes it back. Also reports a done pulse, zero flag and error flag to the control path.

## Interface
- N, 32: datapath width; must match the ALU's N.
- NREGS, 8: register count; fixed at 8 (3-bit indices).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_op  in  3  opcode, equal to ALU select encoding: 0 add, 1 sub, 2 mul, 3 shift-right, 4 and, 5 or, 6 not(op2), 7 reserved.
- in_rd, in_rs1, in_rs2  in  3 each  destination and source register indices.
- in_imm_en  in  1  op2 taken from in_imm instead of rs2.
- in_imm  in  N  immediate operand.
- alu_op1, alu_op2  out  N  to ALU op1/op2.
- alu_sel  out  3  to ALU select.
- alu_q  in  N  ALU result (combinational from alu_op1/op2/alu_sel).
- done  out  1  one-cycle pulse, instruction retired.
- result  out  N  retired value; valid while done=1.
- zero  out  1  result==0; valid while done=1.
- err  out  1  reserved opcode retired; valid while done=1.
- dbg_addr  in  3  debug read index.
- dbg_data  out  N  combinational read of register dbg_addr (r0 reads 0).

## Operation
- States: IDLE, EXEC, WB. Reset state IDLE.
- IDLE: in_ready=1. On in_valid: latch op, rd, op1=R[rs1], op2=(imm_en ? imm : R[rs2]) into operand registers; next EXEC. Otherwise stay.
- EXEC: alu_op1/alu_op2/alu_sel driven from latched registers; capture alu_q into result register (op 7: capture 0, set err); next WB.
- WB: done=1, result/zero/err presented; at end of cycle write result to R[rd] unless rd==0 or err=1; next IDLE.
- r0 hardwired to zero: writes ignored, reads return 0.
- In IDLE and WB, alu_* outputs hold last latched values (no toggling requirement beyond that).
- Widths: all N-bit, results truncated to N bits by the ALU (mul low half, sub wraps mod 2^N); this block adds no extension.
- Reset (any time, including mid-EXEC/WB): state IDLE, all register file entries, operand/result registers and done/zero/err to 0 immediately; in-flight instruction discarded, no writeback.

## Timing
- Reset values: in_ready=1 (IDLE), done=0, result=0, zero=0, err=0, alu_op1=0, alu_op2=0, alu_sel=0, dbg_data=0.
- Accept at edge k; EXEC cycle k+1; WB cycle k+2 (done=1); register write at edge k+3; in_ready=1 in cycle k+3.
- Throughput: one instruction per 3 cycles; next instruction's operand read sees previous writeback (no forwarding needed).
- in_valid while in_ready=0: ignored; upstream must hold instruction until accepted.
- dbg_data reflects writes from the following cycle onward.

## Structure
- Package alu_pkg: opcode enum (OP_ADD=0 … OP_NOT=6, OP_RSVD=7), state enum (IDLE, EXEC, WB), localparam NREGS=8, REG_AW=3.
- Sub-module regfile: 2 combinational read ports + 1 debug read port, 1 synchronous write port, async reset clears all, r0 fixed zero.
- ALU instantiated outside; this block only drives/observes its ports.

## Test plan
- Reset, then write via immediates: op=0 rd=1 rs1=0 imm_en imm=5 -> done in WB cycle k+2, result=5, zero=0; dbg_addr=1 reads 5.
- Register form: R1=5, R2=7 (via immediates), op=1 rd=3 rs1=1 rs2=2 -> result=32'hFFFF_FFFE, R3 updated.
- Back-to-back: hold in_valid high with two dependent instructions (R4=R1+imm 3, then R5=R4 or imm 8) -> accepts 3 cycles apart, R5=8'h08|8 = 8.
- Writes to r0 and zero flag: op=4 rd=0 rs1=1 imm=0 -> result=0, zero=1, R0 still reads 0.
- Reserved op 7 rd=2 -> done, err=1, result=0, R2 unchanged.
- Assert rst during EXEC of op=0 rd=6 imm=9 -> done never pulses, R6=0, in_ready=1 after release, all registers read 0.
